dtw_ref_sched: RTL and testbench
================================

// Module: dtw_ref_sched
// PURPOSE
//  Scheduler/arbiter for the single reference-memory port of dtw_core_ref.
//  Sequences the reference load phase: drives rs/op_mode, then waits for busy to rise and fall.
//  Then shares the DTW_READ address port among NUM_CORES DTW requesters.
//  Arbitration is round-robin; each read returns broadcast data with a per-core valid strobe.
//  Sits between the accelerator top-level control and dtw_core_ref.
// PARAMETERS
//  NUM_CORES   4   number of read requesters, >=2
//  DATA_WIDTH  16  reference sample width
//  ADDR_WIDTH  32  reference address width
//  RD_LATENCY  2   cycles from ref_addr_out to ref_data_in valid (addr reg + RAM)
// PORTS
//  clk_in           in   1                     clock, all logic on posedge
//  rst_in           in   1                     synchronous, active-high reset
//  load_req_in      in   1                     pulse: (re)load reference
//  serve_en_in      in   1                     1: arbitrate reads when loaded
//  ref_loaded_out   out  1                     reference valid, sticky
//  busy_out         out  1                     load or drain in progress
//  req_in           in   NUM_CORES             per-core read request, held until granted
//  addr_in          in   NUM_CORES*ADDR_WIDTH  per-core address, core k at [k*AW +: AW]
//  gnt_out          out  NUM_CORES             one-hot grant pulse
//  rvalid_out       out  NUM_CORES             one-hot data-valid pulse
//  rdata_out        out  DATA_WIDTH            broadcast read data (= ref_data_in)
//  ref_rs_out       out  1                     to dtw_core_ref rs_in
//  ref_op_mode_out  out  1                     to op_mode_in, 0=DTW_READ, 1=LOAD_REF
//  ref_addr_out     out  ADDR_WIDTH            to ref_addr_in
//  ref_busy_in      in   1                     from busy_out
//  ref_data_in      in   DATA_WIDTH            from ref_data_out
// BEHAVIOUR
//  Reset: state IDLE.
//   All outputs 0 except rdata_out, which follows ref_data_in.
//   RR pointer = 0; latency pipe cleared.
//  States:
//   IDLE: rs=0, mode=0.
//    load_req_in -> LOAD_ARM.
//    Else if serve_en_in & ref_loaded_out -> SERVE.
//   SERVE: rs=1, mode=0, arbitrate.
//    load_req_in -> DRAIN.
//    Else if !serve_en_in -> DRAIN_IDLE.
//   DRAIN / DRAIN_IDLE: no new grants.
//    Wait until the latency pipe is empty (at most RD_LATENCY cycles).
//    Then DRAIN -> LOAD_ARM; DRAIN_IDLE -> IDLE.
//   LOAD_ARM: rs=1, mode=1, ref_loaded_out<=0, busy_out=1.
//    ref_busy_in==1 -> LOAD_WAIT.
//   LOAD_WAIT: rs=1, mode=1.
//    ref_busy_in==0 -> ref_loaded_out<=1, rs=0, mode=0, then IDLE.
//  busy_out = 1 in DRAIN, DRAIN_IDLE, LOAD_ARM, LOAD_WAIT.
//  load_req_in is ignored in LOAD_ARM/LOAD_WAIT (no queueing).
//  Arbitration (SERVE only), one grant per cycle:
//   Winner = first k with req_in[k]=1, searching ptr, ptr+1, ... mod NUM_CORES.
//   Registered outputs: next cycle ref_addr_out<=addr_in[winner] and gnt_out<=onehot(winner).
//   ptr <= winner+1, wraps NUM_CORES-1 -> 0.
//   No request: gnt_out=0, ref_addr_out and ptr hold.
//   The requester drops req on the cycle it sees gnt.
//   A req still high on the gnt cycle is treated as a new request.
//  Read return:
//   A gnt_out[k] pulse at cycle t gives rvalid_out[k]=1 at cycle t+RD_LATENCY.
//   rdata_out is valid in that cycle.
//   Back-to-back grants give back-to-back rvalids, in order.
//  Requests seen outside SERVE are never granted; they stay pending.
//  Reset mid-load or mid-serve: immediate return to IDLE.
//   ref_loaded_out=0, in-flight rvalids discarded.
// TESTING
//  1. Reset, then load_req_in pulse; model busy high for 10 cycles.
//     -> rs=1/mode=1 until busy falls; ref_loaded_out=1; back to IDLE.
//  2. Loaded, serve_en=1, only core2 requests addr 0x10.
//     -> gnt_out=4'b0100 with ref_addr_out=0x10; rvalid_out=4'b0100 two cycles later.
//  3. All 4 cores request continuously.
//     -> grants rotate 0,1,2,3,0 on consecutive cycles; rvalid follows each by 2 cycles.
//  4. load_req_in while 2 reads in flight.
//     -> both rvalids delivered, no new gnt; LOAD_ARM entered only after the pipe is empty.
//  5. Core requests while ref_loaded_out=0.
//     -> no gnt until load completes and serve_en=1; then granted.
//  6. rst_in asserted during LOAD_WAIT.
//     -> next cycle IDLE; all outputs 0; ref_loaded_out=0.

Source files
------------

// File: rtl/dtw_ref_sched.sv
// Reference-memory port scheduler for dtw_core_ref.
// Runs the load handshake, then round-robins DTW reads among the cores.
module dtw_ref_sched #(
  parameter int NUM_CORES  = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 32,
  parameter int RD_LATENCY = 2
) (
  input  logic                            clk_in,
  input  logic                            rst_in,
  input  logic                            load_req_in,
  input  logic                            serve_en_in,
  output logic                            ref_loaded_out,
  output logic                            busy_out,
  input  logic [NUM_CORES-1:0]            req_in,
  input  logic [NUM_CORES*ADDR_WIDTH-1:0] addr_in,
  output logic [NUM_CORES-1:0]            gnt_out,
  output logic [NUM_CORES-1:0]            rvalid_out,
  output logic [DATA_WIDTH-1:0]           rdata_out,
  output logic                            ref_rs_out,
  output logic                            ref_op_mode_out,
  output logic [ADDR_WIDTH-1:0]           ref_addr_out,
  input  logic                            ref_busy_in,
  input  logic [DATA_WIDTH-1:0]           ref_data_in
);

  localparam int PW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SERVE,
    S_DRAIN,
    S_DRAIN_IDLE,
    S_LOAD_ARM,
    S_LOAD_WAIT
  } state_t;

  state_t               state;
  state_t               state_nx;
  logic [PW-1:0]        ptr;
  logic [NUM_CORES-1:0] pipe [RD_LATENCY];
  logic                 pipe_empty;
  logic                 grant_en;
  logic                 found;
  logic [PW-1:0]        win;
  logic                 loaded_set;
  logic                 loaded_clr;
  int                   idx;

  // Rotating search starting at ptr
  always_comb begin
    found = 1'b0;
    win   = ptr;
    idx   = 0;
    for (int i = 0; i < NUM_CORES; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_CORES) idx = idx - NUM_CORES;
      if (!found && req_in[idx]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
  end

  always_comb begin
    pipe_empty = (gnt_out == '0);
    for (int i = 0; i < RD_LATENCY; i++)
      if (pipe[i] != '0) pipe_empty = 1'b0;
  end

  always_comb begin
    state_nx        = state;
    grant_en        = 1'b0;
    ref_rs_out      = 1'b0;
    ref_op_mode_out = 1'b0;
    busy_out        = 1'b0;
    loaded_set      = 1'b0;
    loaded_clr      = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (load_req_in)
          state_nx = S_LOAD_ARM;
        else if (serve_en_in && ref_loaded_out)
          state_nx = S_SERVE;
      end
      S_SERVE: begin
        ref_rs_out = 1'b1;
        if (load_req_in)
          state_nx = S_DRAIN;
        else if (!serve_en_in)
          state_nx = S_DRAIN_IDLE;
        else
          grant_en = 1'b1;
      end
      S_DRAIN: begin
        ref_rs_out = 1'b1;
        busy_out   = 1'b1;
        if (pipe_empty) state_nx = S_LOAD_ARM;
      end
      S_DRAIN_IDLE: begin
        ref_rs_out = 1'b1;
        busy_out   = 1'b1;
        if (pipe_empty) state_nx = S_IDLE;
      end
      S_LOAD_ARM: begin
        ref_rs_out      = 1'b1;
        ref_op_mode_out = 1'b1;
        busy_out        = 1'b1;
        if (ref_busy_in) state_nx = S_LOAD_WAIT;
      end
      S_LOAD_WAIT: begin
        ref_rs_out      = 1'b1;
        ref_op_mode_out = 1'b1;
        busy_out        = 1'b1;
        if (!ref_busy_in) begin
          state_nx   = S_IDLE;
          loaded_set = 1'b1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
    if (state_nx == S_LOAD_ARM && state != S_LOAD_ARM)
      loaded_clr = 1'b1;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state          <= S_IDLE;
      ptr            <= '0;
      gnt_out        <= '0;
      ref_addr_out   <= '0;
      ref_loaded_out <= 1'b0;
      for (int i = 0; i < RD_LATENCY; i++)
        pipe[i] <= '0;
    end else begin
      state   <= state_nx;
      gnt_out <= '0;
      if (grant_en && found) begin
        gnt_out      <= NUM_CORES'(1) << win;
        ref_addr_out <= addr_in[win*ADDR_WIDTH +: ADDR_WIDTH];
        ptr          <= (win == PW'(NUM_CORES-1)) ? '0 : win + PW'(1);
      end
      pipe[0] <= gnt_out;
      for (int i = 1; i < RD_LATENCY; i++)
        pipe[i] <= pipe[i-1];
      if (loaded_clr)
        ref_loaded_out <= 1'b0;
      else if (loaded_set)
        ref_loaded_out <= 1'b1;
    end
  end

  assign rvalid_out = pipe[RD_LATENCY-1];
  assign rdata_out  = ref_data_in;

endmodule

// File: tb/tb_dtw_ref_sched.sv
// Scoreboard bench for dtw_ref_sched with an emulated reference core.
// Driver feeds a spec-level model; a negedge monitor pops and compares.
module tb_dtw_ref_sched;

  localparam int N   = 4;
  localparam int DW  = 16;
  localparam int AW  = 32;
  localparam int LAT = 2;

  logic            clk;
  logic            rst_in;
  logic            load_req_in;
  logic            serve_en_in;
  logic            ref_loaded_out;
  logic            busy_out;
  logic [N-1:0]    req_in;
  logic [N*AW-1:0] addr_in;
  logic [N-1:0]    gnt_out;
  logic [N-1:0]    rvalid_out;
  logic [DW-1:0]   rdata_out;
  logic            ref_rs_out;
  logic            ref_op_mode_out;
  logic [AW-1:0]   ref_addr_out;
  logic            ref_busy_in;
  logic [DW-1:0]   ref_data_in;
  logic [AW-1:0]   a_d1;
  logic [AW-1:0]   a_d2;

  dtw_ref_sched #(
    .NUM_CORES (N),
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .RD_LATENCY(LAT)
  ) dut (
    .clk_in         (clk),
    .rst_in         (rst_in),
    .load_req_in    (load_req_in),
    .serve_en_in    (serve_en_in),
    .ref_loaded_out (ref_loaded_out),
    .busy_out       (busy_out),
    .req_in         (req_in),
    .addr_in        (addr_in),
    .gnt_out        (gnt_out),
    .rvalid_out     (rvalid_out),
    .rdata_out      (rdata_out),
    .ref_rs_out     (ref_rs_out),
    .ref_op_mode_out(ref_op_mode_out),
    .ref_addr_out   (ref_addr_out),
    .ref_busy_in    (ref_busy_in),
    .ref_data_in    (ref_data_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
    return a[15:0] ^ {a[7:0], a[31:24]} ^ 16'h5a3c;
  endfunction

  // Reference RAM: address register plus RAM read stage
  always @(posedge clk) begin
    a_d1 <= ref_addr_out;
    a_d2 <= a_d1;
  end
  assign ref_data_in = mem_f(a_d2);

  typedef enum {M_IDLE, M_SERVE, M_DRAIN, M_DRAIN_IDLE,
                M_ARM, M_WAIT} mst_t;

  typedef struct {
    int            cyc;
    logic          rs;
    logic          mode;
    logic          busy;
    logic          loaded;
    logic [N-1:0]  gnt;
    logic [AW-1:0] addr;
  } st_t;

  typedef struct {
    int            cyc;
    int            core;
    logic [DW-1:0] data;
  } rv_t;

  mst_t          ms;
  bit            m_loaded;
  int            m_ptr;
  logic [AW-1:0] m_addr;
  int            last_g;
  bit            pend [N];
  logic [AW-1:0] paddr [N];
  int            busy_cnt;
  st_t           sq [$];
  rv_t           rq [$];
  int            checks = 0;
  int            passes = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s cyc=%0d got=%0h want=%0h",
                  nm, cyc, act, exp);
  endtask

  // Effect of the coming clock edge under the current inputs
  task automatic model_edge();
    st_t s;
    rv_t r;
    int w;
    logic [N-1:0] g;
    g = '0;
    w = -1;
    if (rst_in) begin
      ms       = M_IDLE;
      m_loaded = 0;
      m_ptr    = 0;
      m_addr   = '0;
      last_g   = -100;
      while (rq.size() > 0 && rq[rq.size()-1].cyc > cyc)
        void'(rq.pop_back());
    end else begin
      case (ms)
        M_IDLE: begin
          if (load_req_in) begin
            ms = M_ARM;
            m_loaded = 0;
          end else if (serve_en_in && m_loaded) ms = M_SERVE;
        end
        M_SERVE: begin
          if (load_req_in) ms = M_DRAIN;
          else if (!serve_en_in) ms = M_DRAIN_IDLE;
          else begin
            for (int i = 0; i < N; i++)
              if (w < 0 && pend[(m_ptr+i)%N]) w = (m_ptr + i) % N;
            if (w >= 0) begin
              g[w]    = 1'b1;
              m_addr  = paddr[w];
              m_ptr   = (w + 1) % N;
              pend[w] = 0;
              last_g  = cyc + 1;
              r.cyc   = cyc + 1 + LAT;
              r.core  = w;
              r.data  = mem_f(paddr[w]);
              rq.push_back(r);
            end
          end
        end
        M_DRAIN, M_DRAIN_IDLE: begin
          if (last_g + LAT < cyc) begin
            if (ms == M_DRAIN) begin
              ms = M_ARM;
              m_loaded = 0;
            end else ms = M_IDLE;
          end
        end
        M_ARM: if (ref_busy_in) ms = M_WAIT;
        M_WAIT: begin
          if (!ref_busy_in) begin
            ms = M_IDLE;
            m_loaded = 1;
          end
        end
        default: ms = M_IDLE;
      endcase
    end
    s.cyc    = cyc + 1;
    s.rs     = (ms != M_IDLE);
    s.mode   = (ms == M_ARM || ms == M_WAIT);
    s.busy   = !(ms == M_IDLE || ms == M_SERVE);
    s.loaded = m_loaded;
    s.gnt    = g;
    s.addr   = m_addr;
    sq.push_back(s);
  endtask

  // One cycle: new requests at prob %, core busy emulation, edge
  task automatic tick(input int prob);
    for (int k = 0; k < N; k++) begin
      if (!pend[k] && $urandom_range(99) < prob) begin
        pend[k]  = 1;
        paddr[k] = $urandom;
      end
      req_in[k] = pend[k];
      addr_in[k*AW +: AW] = paddr[k];
    end
    if (ms == M_ARM && busy_cnt == 0) busy_cnt = 10;
    ref_busy_in = (busy_cnt > 0);
    if (busy_cnt > 0) busy_cnt--;
    model_edge();
    @(posedge clk);
    #1;
    load_req_in = 1'b0;
  endtask

  task automatic wait_loaded(input int prob);
    int n;
    n = 0;
    while (!(ms == M_IDLE && m_loaded) && n < 200) begin
      tick(prob);
      n++;
    end
    chk("load_timeout", 64'(n < 200), 64'd1);
  endtask

  task automatic wait_no_pend();
    int n;
    bit any;
    n = 0;
    any = 1;
    while (any && n < 50) begin
      any = 0;
      for (int k = 0; k < N; k++) if (pend[k]) any = 1;
      if (any) begin
        tick(0);
        n++;
      end
    end
    chk("pend_timeout", 64'(n < 50), 64'd1);
  endtask

  always @(negedge clk) begin
    st_t e;
    logic [N-1:0] ev;
    logic [DW-1:0] ed;
    if (sq.size() > 0 && sq[0].cyc < cyc) begin
      chk("status_missed", 64'(sq[0].cyc), 64'(cyc));
      void'(sq.pop_front());
    end
    if (sq.size() > 0 && sq[0].cyc == cyc) begin
      e = sq.pop_front();
      chk("rs", 64'(ref_rs_out), 64'(e.rs));
      chk("op_mode", 64'(ref_op_mode_out), 64'(e.mode));
      chk("busy", 64'(busy_out), 64'(e.busy));
      chk("loaded", 64'(ref_loaded_out), 64'(e.loaded));
      chk("gnt", 64'(gnt_out), 64'(e.gnt));
      chk("ref_addr", 64'(ref_addr_out), 64'(e.addr));
    end
    if (cyc >= 1) begin
      ev = '0;
      ed = '0;
      if (rq.size() > 0 && rq[0].cyc == cyc) begin
        ev[rq[0].core] = 1'b1;
        ed = rq[0].data;
        void'(rq.pop_front());
      end
      chk("rvalid", 64'(rvalid_out), 64'(ev));
      if (ev != '0) chk("rdata", 64'(rdata_out), 64'(ed));
    end
  end

  initial begin
    rst_in      = 1'b1;
    load_req_in = 1'b0;
    serve_en_in = 1'b0;
    req_in      = '0;
    addr_in     = '0;
    ref_busy_in = 1'b0;
    busy_cnt    = 0;
    ms          = M_IDLE;
    m_loaded    = 0;
    last_g      = -100;
    for (int k = 0; k < N; k++) begin
      pend[k]  = 0;
      paddr[k] = '0;
    end
    repeat (3) tick(0);
    rst_in = 1'b0;
    repeat (2) tick(0);

    // Requests before any load stay pending
    serve_en_in = 1'b1;
    repeat (8) tick(50);
    serve_en_in = 1'b0;
    repeat (2) tick(0);

    // Load with core busy for 10 cycles
    load_req_in = 1'b1;
    tick(0);
    wait_loaded(0);
    repeat (2) tick(0);

    // Serve the held requests, then single core2 read
    serve_en_in = 1'b1;
    wait_no_pend();
    pend[2]  = 1;
    paddr[2] = 32'h10;
    repeat (6) tick(0);

    // All cores request every cycle
    for (int k = 0; k < N; k++) begin
      pend[k]  = 1;
      paddr[k] = $urandom;
    end
    repeat (12) tick(100);

    // Reload while reads are in flight
    load_req_in = 1'b1;
    tick(0);
    wait_loaded(60);
    repeat (10) tick(30);

    // Randomized traffic with serve toggles and reloads
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(99) < 3) serve_en_in = ~serve_en_in;
      if ($urandom_range(149) == 0) load_req_in = 1'b1;
      tick(35);
    end
    serve_en_in = 1'b1;
    repeat (4) tick(20);

    // Reset during LOAD_WAIT
    load_req_in = 1'b1;
    tick(0);
    while (ms != M_WAIT && busy_cnt < 20) tick(0);
    repeat (3) tick(0);
    rst_in = 1'b1;
    tick(40);
    rst_in = 1'b0;
    repeat (6) tick(40);
    load_req_in = 1'b1;
    tick(0);
    wait_loaded(40);
    repeat (20) tick(40);

    serve_en_in = 1'b0;
    repeat (10) tick(0);
    @(negedge clk);
    #1;
    chk("rq_empty", 64'(rq.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
